// File: rtl/rom_ctrl_pkg.sv
// Shared types and default widths for the ROM burst arbiter and its
// round-robin sub-arbiter.
package rom_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 4;
    localparam int DEF_ROM_LAT    = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // One entry per issued read, travelling alongside the ROM latency.
    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } rsp_t;

endpackage

// File: rtl/rom_rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, and on a tie the
// pointer decides. The pointer then moves to the loser.
module rom_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Arbitrates two burst requesters onto a fixed-latency ROM and returns the
// read data tagged with requester id and end-of-burst marker.
module rom_burst_arbiter
    import rom_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int ROM_LAT    = DEF_ROM_LAT
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic [1:0]            REQ_I,
    input  logic [ADDR_WIDTH-1:0] ADDR0_I,
    input  logic [ADDR_WIDTH-1:0] ADDR1_I,
    input  logic [LEN_WIDTH-1:0]  LEN0_I,
    input  logic [LEN_WIDTH-1:0]  LEN1_I,
    output logic [1:0]            GNT_O,
    output logic                  ROM_RE_O,
    output logic [ADDR_WIDTH-1:0] ROM_ADDR_O,
    input  logic [DATA_WIDTH-1:0] ROM_DATA_I,
    output logic                  RD_VALID_O,
    output logic [DATA_WIDTH-1:0] RD_DATA_O,
    output logic                  RD_ID_O,
    output logic                  RD_LAST_O,
    output logic                  BUSY_O
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  id_q, id_d;
    logic [1:0]            gnt;
    logic                  arbEn;
    logic                  issue;
    logic                  lastIssue;
    logic                  pipeBusy;
    rsp_t                  issueRsp;
    rsp_t                  pipe_q [ROM_LAT];

    // Grants are only offered in IDLE and never while reset is being applied.
    assign arbEn = (state_q == IDLE) && !RST_I;

    rom_rr_arb2 uArb (
        .clk_i (CLK_I),
        .rst_i (RST_I),
        .en_i  (arbEn),
        .req_i (REQ_I),
        .gnt_o (gnt)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt != 2'b00) state_d = ISSUE;
            ISSUE:   if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue      = (state_q == ISSUE);
        lastIssue  = issue && (cnt_q == '0);
        GNT_O      = gnt;
        ROM_RE_O   = issue;
        ROM_ADDR_O = addr_q;
        issueRsp   = '{valid: issue, id: issue & id_q, last: lastIssue};
    end

    // The address is left untouched on the final issue so it holds while idle.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        id_d   = id_q;
        if (gnt[0]) begin
            addr_d = ADDR0_I;
            cnt_d  = LEN0_I;
            id_d   = 1'b0;
        end else if (gnt[1]) begin
            addr_d = ADDR1_I;
            cnt_d  = LEN1_I;
            id_d   = 1'b1;
        end else if (issue && !lastIssue) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            cnt_d  = cnt_q - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            addr_q <= '0;
            cnt_q  <= '0;
            id_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            id_q   <= id_d;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= issueRsp;
            for (int i = 1; i < ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        pipeBusy = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) pipeBusy = pipeBusy | pipe_q[i].valid;
        BUSY_O     = issue || pipeBusy;
        RD_VALID_O = pipe_q[ROM_LAT-1].valid;
        RD_ID_O    = pipe_q[ROM_LAT-1].id;
        RD_LAST_O  = pipe_q[ROM_LAT-1].last;
        RD_DATA_O  = pipe_q[ROM_LAT-1].valid ? ROM_DATA_I : '0;
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: ROM image ROM[a] = ~a, burst-level reference
// model checked every cycle, directed scenarios plus a randomized phase.
module tb_rom_burst_arbiter;

    localparam int ROM_LAT = 2;

    logic       CLK_I;
    logic       RST_I;
    logic [1:0] REQ_I;
    logic [7:0] ADDR0_I, ADDR1_I;
    logic [3:0] LEN0_I, LEN1_I;
    logic [1:0] GNT_O;
    logic       ROM_RE_O;
    logic [7:0] ROM_ADDR_O;
    logic [7:0] ROM_DATA_I;
    logic       RD_VALID_O;
    logic [7:0] RD_DATA_O;
    logic       RD_ID_O;
    logic       RD_LAST_O;
    logic       BUSY_O;

    rom_burst_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .LEN_WIDTH  (4),
        .ROM_LAT    (ROM_LAT)
    ) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .REQ_I      (REQ_I),
        .ADDR0_I    (ADDR0_I),
        .ADDR1_I    (ADDR1_I),
        .LEN0_I     (LEN0_I),
        .LEN1_I     (LEN1_I),
        .GNT_O      (GNT_O),
        .ROM_RE_O   (ROM_RE_O),
        .ROM_ADDR_O (ROM_ADDR_O),
        .ROM_DATA_I (ROM_DATA_I),
        .RD_VALID_O (RD_VALID_O),
        .RD_DATA_O  (RD_DATA_O),
        .RD_ID_O    (RD_ID_O),
        .RD_LAST_O  (RD_LAST_O),
        .BUSY_O     (BUSY_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    // ROM with fixed read latency; it keeps producing data whatever RE does.
    logic [7:0] romPipe [ROM_LAT];
    always @(posedge CLK_I) begin
        romPipe[0] <= ~ROM_ADDR_O;
        for (int k = 1; k < ROM_LAT; k++) romPipe[k] <= romPipe[k-1];
    end
    assign ROM_DATA_I = romPipe[ROM_LAT-1];

    typedef struct {
        logic [7:0] addr;
        logic       id;
        logic       last;
    } issue_t;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       id;
        logic       last;
    } resp_t;

    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    bit         started    = 0;
    int         reCount    = 0;
    issue_t     issueQ[$];
    resp_t      respQ[$];
    int         grantLog[$];
    resp_t      rspLog[$];
    logic [7:0] lastAddr   = 8'h00;
    int         ptr        = 0;
    bit         modelGranted [2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got timeout, expected completion within budget", name);
    endtask

    // Burst-level reference: a granted burst becomes LEN+1 queued issues, each
    // issue becomes a response due ROM_LAT cycles later.
    always @(negedge CLK_I) begin
        logic [1:0] expGnt;
        logic       expRe, expValid, expBusy, issuing;
        logic [7:0] expAddr;
        int         w;
        issue_t     e;
        if (started) begin
            issuing  = (issueQ.size() != 0);
            expRe    = issuing;
            expAddr  = issuing ? issueQ[0].addr : lastAddr;
            expBusy  = issuing || (respQ.size() != 0);
            expValid = (respQ.size() != 0) && (respQ[0].due == cyc);
            expGnt   = 2'b00;
            w        = 0;
            if (!RST_I && !issuing && REQ_I != 2'b00) begin
                if (REQ_I == 2'b01)      w = 0;
                else if (REQ_I == 2'b10) w = 1;
                else                     w = ptr;
                expGnt = (w == 0) ? 2'b01 : 2'b10;
            end

            checkOutput("gnt", GNT_O, expGnt);
            checkOutput("rom_re", ROM_RE_O, expRe);
            checkOutput("rom_addr", ROM_ADDR_O, expAddr);
            checkOutput("rd_valid", RD_VALID_O, expValid);
            checkOutput("busy", BUSY_O, expBusy);
            if (expValid) begin
                checkOutput("rd_data", RD_DATA_O, respQ[0].data);
                checkOutput("rd_id", RD_ID_O, respQ[0].id);
                checkOutput("rd_last", RD_LAST_O, respQ[0].last);
            end

            if (GNT_O == 2'b01) grantLog.push_back(0);
            if (GNT_O == 2'b10) grantLog.push_back(1);
            if (RD_VALID_O === 1'b1)
                rspLog.push_back('{due: cyc, data: RD_DATA_O, id: RD_ID_O, last: RD_LAST_O});
            if (ROM_RE_O === 1'b1) reCount++;

            if (expValid) void'(respQ.pop_front());
            if (issuing) begin
                e = issueQ.pop_front();
                lastAddr = e.addr;
                respQ.push_back('{due: cyc + ROM_LAT, data: ~e.addr, id: e.id, last: e.last});
            end
            if (expGnt != 2'b00) begin
                int len;
                logic [7:0] base;
                base = (w == 0) ? ADDR0_I : ADDR1_I;
                len  = (w == 0) ? int'(LEN0_I) : int'(LEN1_I);
                for (int k = 0; k <= len; k++)
                    issueQ.push_back('{addr: 8'(base + k), id: w[0], last: (k == len)});
                ptr = 1 - w;
                modelGranted[w] = 1'b1;
            end
            if (RST_I) begin
                issueQ.delete();
                respQ.delete();
                ptr      = 0;
                lastAddr = 8'h00;
            end
        end
        cyc++;
    end

    task automatic stepCycle();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [7:0] a0, input logic [3:0] l0,
                                 input logic [7:0] a1, input logic [3:0] l1);
        REQ_I   = req;
        ADDR0_I = a0;
        LEN0_I  = l0;
        ADDR1_I = a1;
        LEN1_I  = l1;
    endtask

    task automatic waitGrants(input int target, input int budget, input string name);
        int n = 0;
        while (grantLog.size() < target && n < budget) begin
            stepCycle();
            n++;
        end
        if (grantLog.size() < target) timeoutFail(name);
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n = 0;
        while ((issueQ.size() != 0 || respQ.size() != 0) && n < budget) begin
            stepCycle();
            n++;
        end
        if (issueQ.size() != 0 || respQ.size() != 0) timeoutFail(name);
        stepCycle();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected simulation end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rb, gb, rc;
        logic [7:0] exp023 [4];
        logic [7:0] exp025 [4];
        logic       reqBit [2];
        exp023 = '{8'hEF, 8'hEE, 8'hED, 8'hEC};
        exp025 = '{8'h01, 8'h00, 8'hFF, 8'hFE};

        RST_I = 1'b1;
        applyStimulus(2'b00, 8'h00, 4'h0, 8'h00, 4'h0);
        stepCycle();
        started = 1;
        stepCycle();
        stepCycle();
        RST_I = 1'b0;

        $display("[TB] idle after reset");
        repeat (20) stepCycle();
        checkOutput("idle_re_count", reCount, 0);
        checkOutput("idle_rsp_count", rspLog.size(), 0);

        $display("[TB] single burst, requester 0");
        rb = rspLog.size();
        gb = grantLog.size();
        applyStimulus(2'b01, 8'h10, 4'd3, 8'h00, 4'h0);
        waitGrants(gb + 1, 20, "t023_grant");
        applyStimulus(2'b00, 8'h10, 4'd3, 8'h00, 4'h0);
        waitIdle(40, "t023_idle");
        checkOutput("t023_grant_count", grantLog.size() - gb, 1);
        checkOutput("t023_grant_id", grantLog[gb], 0);
        checkOutput("t023_rsp_count", rspLog.size() - rb, 4);
        if (rspLog.size() - rb == 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("t023_data", rspLog[rb+k].data, exp023[k]);
                checkOutput("t023_id", rspLog[rb+k].id, 0);
                checkOutput("t023_last", rspLog[rb+k].last, (k == 3) ? 1 : 0);
            end
        end

        $display("[TB] wrapping burst, requester 1");
        rb = rspLog.size();
        gb = grantLog.size();
        applyStimulus(2'b10, 8'h00, 4'h0, 8'hFE, 4'd3);
        waitGrants(gb + 1, 20, "t025_grant");
        applyStimulus(2'b00, 8'h00, 4'h0, 8'hFE, 4'd3);
        waitIdle(40, "t025_idle");
        checkOutput("t025_rsp_count", rspLog.size() - rb, 4);
        if (rspLog.size() - rb == 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("t025_data", rspLog[rb+k].data, exp025[k]);
                checkOutput("t025_id", rspLog[rb+k].id, 1);
            end
        end

        $display("[TB] both requesting, single-word bursts");
        rb = rspLog.size();
        gb = grantLog.size();
        applyStimulus(2'b11, 8'h00, 4'd0, 8'h80, 4'd0);
        waitGrants(gb + 4, 40, "t024_grants");
        applyStimulus(2'b00, 8'h00, 4'd0, 8'h80, 4'd0);
        waitIdle(40, "t024_idle");
        checkOutput("t024_grant_count", grantLog.size() - gb, 4);
        checkOutput("t024_rsp_count", rspLog.size() - rb, 4);
        if (grantLog.size() - gb == 4 && rspLog.size() - rb == 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("t024_grant_id", grantLog[gb+k], k % 2);
                checkOutput("t024_rsp_id", rspLog[rb+k].id, k % 2);
                checkOutput("t024_data", rspLog[rb+k].data, (k % 2 == 0) ? 8'hFF : 8'h7F);
            end
        end

        $display("[TB] sixteen-word burst");
        rb = rspLog.size();
        rc = reCount;
        gb = grantLog.size();
        applyStimulus(2'b01, 8'h30, 4'd15, 8'h00, 4'h0);
        waitGrants(gb + 1, 20, "t026_grant");
        applyStimulus(2'b00, 8'h30, 4'd15, 8'h00, 4'h0);
        waitIdle(60, "t026_idle");
        checkOutput("t026_re_count", reCount - rc, 16);
        checkOutput("t026_rsp_count", rspLog.size() - rb, 16);
        if (rspLog.size() - rb == 16) begin
            checkOutput("t026_first_data", rspLog[rb].data, 8'hCF);
            checkOutput("t026_last_data", rspLog[rb+15].data, 8'hC0);
            checkOutput("t026_first_last", rspLog[rb].last, 0);
            checkOutput("t026_final_last", rspLog[rb+15].last, 1);
        end

        $display("[TB] reset during burst");
        rb = rspLog.size();
        gb = grantLog.size();
        applyStimulus(2'b01, 8'h40, 4'd3, 8'h00, 4'h0);
        waitGrants(gb + 1, 20, "t027_grant");
        applyStimulus(2'b00, 8'h40, 4'd3, 8'h00, 4'h0);
        stepCycle();
        RST_I = 1'b1;
        stepCycle();
        RST_I = 1'b0;
        @(negedge CLK_I);
        #1;
        checkOutput("t027_gnt", GNT_O, 0);
        checkOutput("t027_re", ROM_RE_O, 0);
        checkOutput("t027_addr", ROM_ADDR_O, 0);
        checkOutput("t027_valid", RD_VALID_O, 0);
        checkOutput("t027_data", RD_DATA_O, 0);
        checkOutput("t027_id", RD_ID_O, 0);
        checkOutput("t027_last", RD_LAST_O, 0);
        checkOutput("t027_busy", BUSY_O, 0);
        repeat (6) stepCycle();
        checkOutput("t027_no_rsp", rspLog.size() - rb, 0);
        gb = grantLog.size();
        applyStimulus(2'b11, 8'h00, 4'd0, 8'h80, 4'd0);
        waitGrants(gb + 1, 20, "t027_regrant");
        applyStimulus(2'b00, 8'h00, 4'd0, 8'h80, 4'd0);
        if (grantLog.size() > gb) checkOutput("t027_regrant_id", grantLog[gb], 0);
        waitIdle(40, "t027_idle");

        $display("[TB] randomized traffic");
        reqBit[0] = 1'b0;
        reqBit[1] = 1'b0;
        modelGranted[0] = 1'b0;
        modelGranted[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            stepCycle();
            for (int i = 0; i < 2; i++) begin
                if (!reqBit[i] || modelGranted[i]) begin
                    modelGranted[i] = 1'b0;
                    reqBit[i] = ($urandom_range(0, 2) == 0);
                    if (i == 0) begin
                        ADDR0_I = 8'($urandom_range(0, 255));
                        LEN0_I  = 4'($urandom_range(0, 15));
                    end else begin
                        ADDR1_I = 8'($urandom_range(0, 255));
                        LEN1_I  = 4'($urandom_range(0, 15));
                    end
                end
            end
            REQ_I = {reqBit[1], reqBit[0]};
        end
        REQ_I = 2'b00;
        waitIdle(200, "random_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
